key_fifo: RTL and testbench

Buffers decoded keystrokes between the PS/2 `keyboard` stage and the CPU keyboard port, and generates typematic auto-repeat for a held key. It consumes the single-cycle press/release pulses and ASCII code produced by `keyboard`. It holds up to DEPTH characters in a FIFO and presents the oldest one to the CPU with an available flag, which the CPU clears with a read strobe. Overflow is recorded in a sticky flag.

---
 rtl/key_fifo.sv | 156 +++++++++++++++
 tb/tb_key_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/key_fifo.sv
// Keystroke FIFO between the PS/2 decoder and the CPU keyboard port.
// It also generates typematic auto-repeat entries for the key that is currently held.
module key_fifo #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned REPEAT_DELAY  = 5000000,
    parameter int unsigned REPEAT_PERIOD = 1000000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_ascii_code,
    input  logic                     i_key_press,
    input  logic                     i_key_release,
    input  logic                     i_rd,
    output logic [7:0]               o_data,
    output logic                     o_avail,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = AW + 1;
    localparam int unsigned RMAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CTR_W  = ($clog2(RMAX) < 1) ? 1 : $clog2(RMAX);

    localparam logic [CTR_W-1:0] DELAY_LAST  = CTR_W'(REPEAT_DELAY - 1);
    localparam logic [CTR_W-1:0] PERIOD_LAST = CTR_W'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0]    FULL_CNT    = CW'(DEPTH);
    localparam logic [CW-1:0]    HALF_CNT    = CW'(DEPTH / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CTR_W-1:0]  ctr, ctr_nxt;
    logic [7:0]        held, held_nxt;
    logic              rep_fire;

    logic [7:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              full;
    logic              pop;
    logic              press_push;
    logic              rep_push;
    logic              push;
    logic              ovf_set;
    logic [7:0]        wdata;
    logic [7:0]        head_nxt;

    // Repeat FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            ctr   <= '0;
            held  <= 8'h00;
        end else begin
            state <= state_nxt;
            ctr   <= ctr_nxt;
            held  <= held_nxt;
        end
    end

    // Any release cancels repeat regardless of its code, so a Shift change can't leave a stuck key
    always_comb begin
        state_nxt = state;
        ctr_nxt   = ctr;
        held_nxt  = held;
        rep_fire  = 1'b0;
        if (i_key_press) begin
            held_nxt  = i_ascii_code;
            ctr_nxt   = '0;
            state_nxt = i_key_release ? IDLE : DELAY;
        end else if (i_key_release) begin
            ctr_nxt   = '0;
            state_nxt = IDLE;
        end else begin
            case (state)
                DELAY: begin
                    if (ctr == DELAY_LAST) begin
                        rep_fire  = 1'b1;
                        ctr_nxt   = '0;
                        state_nxt = REPEAT;
                    end else begin
                        ctr_nxt = ctr + CTR_W'(1);
                    end
                end
                REPEAT: begin
                    if (ctr == PERIOD_LAST) begin
                        rep_fire = 1'b1;
                        ctr_nxt  = '0;
                    end else begin
                        ctr_nxt = ctr + CTR_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Push/pop arbitration; repeats are throttled to half the FIFO so presses always fit
    always_comb begin
        full       = (o_count == FULL_CNT);
        pop        = i_rd && (o_count != '0);
        press_push = i_key_press && (!full || i_rd);
        rep_push   = rep_fire && !i_key_press && (o_count < HALF_CNT);
        push       = press_push || rep_push;
        ovf_set    = i_key_press && full && !i_rd;
        wdata      = i_key_press ? i_ascii_code : held;
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = o_count;
        case ({push, pop})
            2'b10:   count_nxt = o_count + CW'(1);
            2'b01:   count_nxt = o_count - CW'(1);
            default: count_nxt = o_count;
        endcase
        // Bypass the write when it lands on the next head slot
        head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
    end

    // FIFO storage, pointers and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_avail    <= 1'b0;
            o_data     <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_ptr_nxt;
            o_count <= count_nxt;
            o_avail <= (count_nxt != '0);
            o_data  <= head_nxt;
            if (ovf_set) begin
                o_overflow <= 1'b1;
            end else if (i_rd) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_fifo.sv
// Directed bench for key_fifo using DEPTH=8, REPEAT_DELAY=20 and REPEAT_PERIOD=5.
// The expected values are computed by hand from the cycle timing of the block.
module tb_key_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] ascii_code;
    logic       key_press;
    logic       key_release;
    logic       rd;
    logic [7:0] data;
    logic       avail;
    logic       overflow;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    key_fifo #(
        .DEPTH        (8),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ascii_code (ascii_code),
        .i_key_press  (key_press),
        .i_key_release(key_release),
        .i_rd         (rd),
        .o_data       (data),
        .o_avail      (avail),
        .o_overflow   (overflow),
        .o_count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] c);
        ascii_code = c;
        key_press  = 1'b1;
        tick(1);
        key_press  = 1'b0;
    endtask

    task automatic release_key();
        key_release = 1'b1;
        tick(1);
        key_release = 1'b0;
    endtask

    task automatic read1();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick(2);
        #2 rst_n = 1'b1;
        tick(1);
    endtask

    logic [7:0] exp_q [$];

    initial begin
        rst_n       = 1'b0;
        ascii_code  = 8'h00;
        key_press   = 1'b0;
        key_release = 1'b0;
        rd          = 1'b0;

        // Reset state and basic repeat timing
        do_reset();
        tick(8);
        check("rst_avail", 32'(avail), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_data", 32'(data), 32'h00);
        check("rst_ovf", 32'(overflow), 32'd0);
        press(8'h61);
        check("press_data", 32'(data), 32'h61);
        check("press_count", 32'(count), 32'd1);
        check("press_avail", 32'(avail), 32'd1);
        tick(19);
        check("pre_repeat_count", 32'(count), 32'd1);
        tick(1);
        check("first_repeat_count", 32'(count), 32'd2);
        tick(4);
        check("pre_second_repeat", 32'(count), 32'd2);
        tick(1);
        check("second_repeat_count", 32'(count), 32'd3);
        release_key();
        tick(20);
        check("after_release_count", 32'(count), 32'd3);
        check("after_release_data", 32'(data), 32'h61);

        // Repeat throttle at DEPTH/2
        do_reset();
        press(8'h6b);
        tick(20);
        check("thr_count2", 32'(count), 32'd2);
        tick(5);
        check("thr_count3", 32'(count), 32'd3);
        tick(5);
        check("thr_count4", 32'(count), 32'd4);
        tick(30);
        check("thr_hold4", 32'(count), 32'd4);
        check("thr_ovf", 32'(overflow), 32'd0);
        release_key();

        // Overflow and full handling
        do_reset();
        for (int i = 0; i < 9; i++) press(8'(8'h41 + i));
        check("ovf_count", 32'(count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(data), 32'h41);
        read1();
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_next_head", 32'(data), 32'h42);
        check("ovf_count7", 32'(count), 32'd7);
        press(8'h50);
        check("refill_count", 32'(count), 32'd8);
        rd = 1'b1;
        press(8'h51);
        rd = 1'b0;
        check("full_rw_count", 32'(count), 32'd8);
        check("full_rw_ovf", 32'(overflow), 32'd0);
        release_key();
        exp_q = '{8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h50, 8'h51};
        for (int i = 0; i < 8; i++) begin
            check("drain_data", 32'(data), 32'(exp_q[i]));
            read1();
        end
        check("drain_empty", 32'(avail), 32'd0);

        // Wrap-around: push and pop one at a time with no repeat
        do_reset();
        for (int i = 0; i < 20; i++) begin
            ascii_code  = 8'(8'h30 + i);
            key_press   = 1'b1;
            key_release = 1'b1;
            tick(1);
            key_press   = 1'b0;
            key_release = 1'b0;
            check("wrap_data", 32'(data), 32'(8'h30 + i));
            check("wrap_avail", 32'(avail), 32'd1);
            read1();
            check("wrap_avail_drop", 32'(avail), 32'd0);
        end
        read1();
        check("empty_rd_count", 32'(count), 32'd0);
        check("empty_rd_avail", 32'(avail), 32'd0);

        // Re-press restarts delay with the new code
        do_reset();
        press(8'h61);
        tick(15);
        press(8'h62);
        check("repress_count", 32'(count), 32'd2);
        tick(19);
        check("repress_pre", 32'(count), 32'd2);
        tick(1);
        check("repress_first", 32'(count), 32'd3);
        read1();
        check("repress_head_b", 32'(data), 32'h62);
        read1();
        check("repress_repeat_b", 32'(data), 32'h62);
        tick(3);

        // Asynchronous reset mid-repeat, between edges
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_avail", 32'(avail), 32'd0);
        check("async_data", 32'(data), 32'h00);
        tick(2);
        #2 rst_n = 1'b1;
        tick(30);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_avail", 32'(avail), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
